raw_line_buffer_7row: RTL and testbench
=======================================

Name: raw_line_buffer_7row

Overview:
Upstream stage of the 7x7 Bayer demosaic core. Takes a raster RAW pixel stream, one pixel per clock, and stores the previous 6 lines. Each accepted pixel produces one 7-row column D0..D6 for the demosaic window shift registers, plus the X/Y CFA phase bits of the window centre.

Parameters:
PIX_W, 10, pixel width in bits
IMG_WIDTH, 1920, maximum pixels per line; depth of each line RAM
ADDR_W, $clog2(IMG_WIDTH), line RAM address width
CFA_X0, 0, X phase of column 0
CFA_Y0, 0, Y phase of line 0

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
IN_PIX  in  PIX_W  raw pixel
IN_VALID  in  1  pixel qualifier
IN_SOF  in  1  first pixel of frame; qualified by IN_VALID
IN_EOL  in  1  last pixel of line; qualified by IN_VALID
D0..D6  out  PIX_W each  column rows; D0 = oldest line (n-6), D6 = current line n
X  out  1  column phase of the window centre
Y  out  1  row phase of the window centre
OUT_VALID  out  1  D0..D6/X/Y valid
OUT_SOF  out  1  IN_SOF delayed to match data
OUT_EOL  out  1  IN_EOL delayed to match data
ERR_LEN  out  1  sticky line-length error

Behaviour:
- Single clock CLK. RST is synchronous, active-high.
- Reset: all outputs 0, col_cnt=0, rows_valid=0, row_par=0, ERR_LEN=0. RAM contents are not cleared; they are masked by rows_valid.
- Storage: 6 line RAMs L0..L5, each IMG_WIDTH x PIX_W, read-first, one read and one write per cycle at address col_cnt.
- On an accepted pixel (IN_VALID=1, col_cnt<IMG_WIDTH):
  - Read Lk[col_cnt] for k=0..5.
  - Write L0[col_cnt]=IN_PIX and Lk[col_cnt]=old L(k-1)[col_cnt] (cascade).
- Latency is exactly 1 cycle: D6=IN_PIX, D(5-k)=old Lk value, OUT_VALID=IN_VALID, all registered.
- When IN_VALID=0, D0..D6/X/Y hold and OUT_VALID=0.
- Counters:
  - col_cnt increments per accepted pixel. It returns to 0 after IN_EOL.
  - IN_SOF forces col_cnt=0 for that pixel, rows_valid=0 and row_par=CFA_Y0.
  - IN_EOL toggles row_par and increments rows_valid, saturating at 6.
  - IN_SOF and IN_EOL on the same pixel (1-pixel line) apply both, SOF first.
- Row masking: Dk (k=0..5) is forced to 0 when (6-k) > rows_valid. D6 is never masked.
- Phase (window centre is 3 columns behind D6 and on row D3):
  - X = col_cnt[0] ^ 1 ^ CFA_X0 (parity of col-3).
  - Y = row_par ^ 1 (parity of line-3).
  - X/Y are registered with the data.
- Length errors:
  - IN_EOL with col_cnt != IMG_WIDTH-1 sets ERR_LEN. The line is accepted as short and col_cnt resets.
  - A pixel arriving when col_cnt == IMG_WIDTH (no EOL seen) is dropped: no RAM write, OUT_VALID=0. It sets ERR_LEN.
  - ERR_LEN is cleared only by RST or IN_SOF.
- Reset mid-frame: takes effect next edge. Output restarts cleanly at the next IN_SOF; before that, lines are accepted with rows_valid counting from 0.
- Within a line, IN_VALID must be contiguous, because the downstream window shifts every clock. Gaps are allowed only between lines.

Optional Feature:
Macro BORDER_REPLICATE_EN.
- Defined: masked rows are not zeroed. Each masked row Dk outputs the oldest valid row D(6-rows_valid). With rows_valid=0, all rows equal D6.
- Undefined: masked rows output 0, as described above.

Decomposition:
- Shared package raw_lb_pkg: PIX_W default, ADDR_W function, ROWS=7, typedef pix_t, CFA phase constants.
- One sub-module raw_line_ram: single-clock read-first simple dual-port RAM (ADDR_W, PIX_W), instantiated 6 times.
- Counters, masking and phase logic stay in the top module.

Test Plan:
1. IMG_WIDTH=8, frame of 8 lines, pixel = line*16+col; sample at line 7, col 2 (after the stall) -> D0..D6 = 0x12,0x22,...,0x72; OUT_VALID one cycle after IN_VALID.
2. Same frame, sample at line 2, col 0 -> D0..D3=0, D4=0x00, D5=0x10, D6=0x20. With BORDER_REPLICATE_EN: D0..D4=0x00.
3. CFA_X0=0, CFA_Y0=0, line 4, col 5 -> X=0, Y=1. Col 6 -> X=1.
4. IN_EOL at col 5 with IMG_WIDTH=8 -> ERR_LEN=1 sticky. Next IN_SOF clears it. The 9th pixel of an EOL-less line gives OUT_VALID=0 and no RAM write.
5. RST=1 asserted at line 5, col 3 -> next cycle all outputs 0. After a new IN_SOF, the first line gives D0..D5=0.
6. Single-pixel line (IN_SOF and IN_EOL together), then next line -> rows_valid=1 and D5 equals the first pixel at col 0.

Source files
------------

// File: rtl/raw_lb_pkg.sv
// Shared constants, pixel type and address-width helper for the RAW line buffer.
// No logic and no latency; nothing here applies backpressure.
package raw_lb_pkg;

  localparam int PIX_W_DEF  = 10;
  localparam int ROWS       = 7;
  localparam int LINES      = ROWS - 1;
  localparam int CFA_X0_DEF = 0;
  localparam int CFA_Y0_DEF = 0;

  typedef logic [PIX_W_DEF-1:0] pix_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/raw_line_ram.sv
// One stored line: single-clock simple dual-port RAM with read-first behaviour.
// Combinational read, write on the clock edge; no backpressure.
module raw_line_ram #(
  parameter int ADDR_W = 11,
  parameter int PIX_W  = 10,
  parameter int DEPTH  = 1920
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_dat,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_dat
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_dat;
  end

  // Read returns the pre-write value, which the cascade relies on.
  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/raw_line_buffer_7row.sv
// 7-row column generator for the 7x7 demosaic: 6 cascaded line RAMs, 1-cycle registered latency,
// no backpressure (overlong pixels dropped). BORDER_REPLICATE_EN: masked rows repeat the oldest valid row.
module raw_line_buffer_7row
  import raw_lb_pkg::*;
#(
  parameter int PIX_W     = PIX_W_DEF,
  parameter int IMG_WIDTH = 1920,
  parameter int ADDR_W    = addr_w(IMG_WIDTH),
  parameter int CFA_X0    = CFA_X0_DEF,
  parameter int CFA_Y0    = CFA_Y0_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [PIX_W-1:0] IN_PIX,
  input  logic             IN_VALID,
  input  logic             IN_SOF,
  input  logic             IN_EOL,
  output logic [PIX_W-1:0] D0,
  output logic [PIX_W-1:0] D1,
  output logic [PIX_W-1:0] D2,
  output logic [PIX_W-1:0] D3,
  output logic [PIX_W-1:0] D4,
  output logic [PIX_W-1:0] D5,
  output logic [PIX_W-1:0] D6,
  output logic             X,
  output logic             Y,
  output logic             OUT_VALID,
  output logic             OUT_SOF,
  output logic             OUT_EOL,
  output logic             ERR_LEN
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] COL_MAX  = CNT_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_WIDTH - 1);

  logic [CNT_W-1:0] col_q, col_d, col_eff;
  logic [2:0]       rv_q, rv_d, rv_eff;
  logic             par_q, par_d, par_eff;
  logic             err_q, err_d;
  logic             x_q, x_d, y_q, y_d;
  logic             vld_q, vld_d, sof_q, sof_d, eol_q, eol_d;
  logic             accept;
  logic [PIX_W-1:0] row_q [ROWS];
  logic [PIX_W-1:0] row_d [ROWS];
  logic [PIX_W-1:0] raw_row [ROWS];
  logic [PIX_W-1:0] rd_dat [LINES];
  logic [PIX_W-1:0] wr_dat [LINES];
`ifdef BORDER_REPLICATE_EN
  logic [PIX_W-1:0] oldest;
`endif

  for (genvar k = 0; k < LINES; k++) begin : g_line
    raw_line_ram #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .DEPTH(IMG_WIDTH)) u_line (
      .clk    (CLK),
      .we     (accept),
      .wr_addr(col_eff[ADDR_W-1:0]),
      .wr_dat (wr_dat[k]),
      .rd_addr(col_eff[ADDR_W-1:0]),
      .rd_dat (rd_dat[k])
    );
  end

  always_comb begin
    // SOF restarts the counters for its own pixel, not just the next one.
    col_eff = IN_SOF ? '0 : col_q;
    rv_eff  = IN_SOF ? 3'd0 : rv_q;
    par_eff = IN_SOF ? CFA_Y0[0] : par_q;
    accept  = IN_VALID && (col_eff < COL_MAX);

    raw_row[ROWS-1] = IN_PIX;
    wr_dat[0]       = IN_PIX;
    for (int k = 0; k < LINES; k++) raw_row[LINES-1-k] = rd_dat[k];
    for (int k = 1; k < LINES; k++) wr_dat[k] = rd_dat[k-1];
`ifdef BORDER_REPLICATE_EN
    oldest = raw_row[3'd6 - rv_eff];
`endif

    row_d = row_q;
    col_d = col_q;
    rv_d  = rv_q;
    par_d = par_q;
    err_d = err_q;
    x_d   = x_q;
    y_d   = y_q;
    vld_d = 1'b0;
    sof_d = 1'b0;
    eol_d = 1'b0;

    if (IN_VALID) begin
      col_d = col_eff;
      rv_d  = rv_eff;
      par_d = par_eff;
      err_d = IN_SOF ? 1'b0 : err_q;
      if (accept) begin
        for (int j = 0; j < ROWS - 1; j++) begin
          if ((ROWS - 1 - j) > int'(rv_eff)) begin
`ifdef BORDER_REPLICATE_EN
            row_d[j] = oldest;
`else
            row_d[j] = '0;
`endif
          end else begin
            row_d[j] = raw_row[j];
          end
        end
        row_d[ROWS-1] = IN_PIX;
        x_d   = col_eff[0] ^ 1'b1 ^ CFA_X0[0];
        y_d   = ~par_eff;
        vld_d = 1'b1;
        sof_d = IN_SOF;
        eol_d = IN_EOL;
        col_d = col_eff + CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
      if (IN_EOL) begin
        col_d = '0;
        rv_d  = (rv_eff == 3'd6) ? 3'd6 : rv_eff + 3'd1;
        par_d = ~par_eff;
        if (col_eff != COL_LAST) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      col_q <= '0;
      rv_q  <= 3'd0;
      par_q <= 1'b0;
      err_q <= 1'b0;
      x_q   <= 1'b0;
      y_q   <= 1'b0;
      vld_q <= 1'b0;
      sof_q <= 1'b0;
      eol_q <= 1'b0;
      for (int j = 0; j < ROWS; j++) row_q[j] <= '0;
    end else begin
      col_q <= col_d;
      rv_q  <= rv_d;
      par_q <= par_d;
      err_q <= err_d;
      x_q   <= x_d;
      y_q   <= y_d;
      vld_q <= vld_d;
      sof_q <= sof_d;
      eol_q <= eol_d;
      for (int j = 0; j < ROWS; j++) row_q[j] <= row_d[j];
    end
  end

  assign D0 = row_q[0];
  assign D1 = row_q[1];
  assign D2 = row_q[2];
  assign D3 = row_q[3];
  assign D4 = row_q[4];
  assign D5 = row_q[5];
  assign D6 = row_q[6];
  assign X         = x_q;
  assign Y         = y_q;
  assign OUT_VALID = vld_q;
  assign OUT_SOF   = sof_q;
  assign OUT_EOL   = eol_q;
  assign ERR_LEN   = err_q;

endmodule

// File: tb/tb_raw_line_buffer_7row.sv
// Bench for raw_line_buffer_7row at IMG_WIDTH=8: directed sequences, a vector table and random frames
// checked every cycle against a per-column line-history model.
module tb_raw_line_buffer_7row;

  localparam int W      = 8;
  localparam int CFA_X0 = 0;
  localparam int CFA_Y0 = 0;

  logic       CLK = 1'b0;
  logic       RST, IN_VALID, IN_SOF, IN_EOL;
  logic [9:0] IN_PIX;
  logic [9:0] d0, d1, d2, d3, d4, d5, d6;
  logic       X, Y, OUT_VALID, OUT_SOF, OUT_EOL, ERR_LEN;
  logic [9:0] dut_d [7];

  assign dut_d[0] = d0;
  assign dut_d[1] = d1;
  assign dut_d[2] = d2;
  assign dut_d[3] = d3;
  assign dut_d[4] = d4;
  assign dut_d[5] = d5;
  assign dut_d[6] = d6;

  raw_line_buffer_7row #(.PIX_W(10), .IMG_WIDTH(W), .CFA_X0(CFA_X0), .CFA_Y0(CFA_Y0)) dut (
    .CLK(CLK), .RST(RST), .IN_PIX(IN_PIX), .IN_VALID(IN_VALID), .IN_SOF(IN_SOF), .IN_EOL(IN_EOL),
    .D0(d0), .D1(d1), .D2(d2), .D3(d3), .D4(d4), .D5(d5), .D6(d6),
    .X(X), .Y(Y), .OUT_VALID(OUT_VALID), .OUT_SOF(OUT_SOF), .OUT_EOL(OUT_EOL), .ERR_LEN(ERR_LEN)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Model: each column keeps the history of pixels written there, newest first.
  logic [9:0] colhist [W][$];
  int         m_col, m_rows;
  bit         m_par, m_err;
  logic [9:0] e_d [7];
  bit         e_known [7];
  bit         e_ov, e_sof, e_eol, e_x, e_y;

  typedef struct {
    bit         v, s, e;
    logic [9:0] p;
    bit         ov, err;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit rst, input bit v, input bit s, input bit e, input logic [9:0] p);
    int c, rv;
    bit par;
    if (rst) begin
      m_col = 0; m_rows = 0; m_par = 1'b0; m_err = 1'b0;
      e_ov = 0; e_sof = 0; e_eol = 0; e_x = 0; e_y = 0;
      for (int j = 0; j < 7; j++) begin e_d[j] = '0; e_known[j] = 1'b1; end
      return;
    end
    e_ov = 0; e_sof = 0; e_eol = 0;
    if (!v) return;
    c   = s ? 0 : m_col;
    rv  = s ? 0 : m_rows;
    par = s ? 1'(CFA_Y0) : m_par;
    if (s) m_err = 1'b0;
    if (c < W) begin
      e_ov = 1; e_sof = s; e_eol = e;
      e_x  = 1'(((c % 2) ^ 1 ^ CFA_X0) != 0);
      e_y  = ~par;
      e_d[6] = p; e_known[6] = 1'b1;
      for (int m = 1; m <= 6; m++) begin
        if (m <= rv) begin
          e_known[6-m] = (colhist[c].size() >= m);
          e_d[6-m]     = e_known[6-m] ? colhist[c][m-1] : '0;
        end else begin
          e_d[6-m] = '0; e_known[6-m] = 1'b1;
        end
      end
`ifdef BORDER_REPLICATE_EN
      for (int j = 0; j < 6; j++) begin
        if ((6 - j) > rv) begin e_d[j] = e_d[6-rv]; e_known[j] = e_known[6-rv]; end
      end
`endif
      colhist[c].push_front(p);
      if (colhist[c].size() > 6) void'(colhist[c].pop_back());
      m_col = c + 1;
    end else begin
      m_err = 1'b1;
    end
    if (e) begin
      if (c != W - 1) m_err = 1'b1;
      m_col  = 0;
      m_rows = (rv == 6) ? 6 : rv + 1;
      m_par  = ~par;
    end else begin
      m_rows = rv;
      m_par  = par;
    end
  endtask

  task automatic compare_all();
    chk("ov",  int'(OUT_VALID), int'(e_ov));
    chk("sof", int'(OUT_SOF),   int'(e_sof));
    chk("eol", int'(OUT_EOL),   int'(e_eol));
    chk("err", int'(ERR_LEN),   int'(m_err));
    chk("x",   int'(X),         int'(e_x));
    chk("y",   int'(Y),         int'(e_y));
    for (int j = 0; j < 7; j++)
      if (e_known[j]) chk($sformatf("d%0d", j), int'(dut_d[j]), int'(e_d[j]));
  endtask

  task automatic step(input bit rst, input bit v, input bit s, input bit e, input logic [9:0] p);
    RST = rst; IN_VALID = v; IN_SOF = s; IN_EOL = e; IN_PIX = p;
    @(posedge CLK);
    #1;
    model_update(rst, v, s, e, p);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0);
  endtask

  task automatic add(input bit v, input bit s, input bit e, input logic [9:0] p, input bit ov, input bit err);
    vec_t r;
    r.v = v; r.s = s; r.e = e; r.p = p; r.ov = ov; r.err = err;
    tbl.push_back(r);
  endtask

  initial begin
    // Length-error vector table, applied after the first frame.
    for (int c = 0; c < 8; c++) add(1, c == 0, c == 7, 10'(16'h100 + c), 1, 0);
    add(0, 0, 0, '0, 0, 0);
    for (int c = 0; c < 6; c++) add(1, 0, c == 5, 10'(16'h110 + c), 1, c == 5);
    add(0, 0, 0, '0, 0, 1);
    for (int c = 0; c < 8; c++) add(1, 0, c == 7, 10'(16'h120 + c), 1, 1);
    add(0, 0, 0, '0, 0, 1);
    for (int c = 0; c < 9; c++) add(1, 0, 0, 10'(16'h130 + c), c < 8, 1);
    add(1, 0, 1, 10'h13f, 0, 1);
    add(0, 0, 0, '0, 0, 1);
    for (int c = 0; c < 8; c++) add(1, 0, c == 7, 10'(16'h140 + c), 1, 1);
    add(0, 0, 0, '0, 0, 1);
    for (int c = 0; c < 8; c++) add(1, c == 0, c == 7, 10'(16'h150 + c), 1, 0);
    add(0, 0, 0, '0, 0, 0);

    RST = 1'b1; IN_VALID = 0; IN_SOF = 0; IN_EOL = 0; IN_PIX = '0;
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    for (int j = 0; j < 7; j++) chk("rst_d", int'(dut_d[j]), 0);
    chk("rst_ov", int'(OUT_VALID), 0);
    chk("rst_err", int'(ERR_LEN), 0);
    idle(1);

    // Frame A: pixel = line*16 + col, two idle cycles between lines.
    for (int ln = 0; ln < 8; ln++) begin
      for (int c = 0; c < 8; c++) begin
        step(0, 1, ln == 0 && c == 0, c == 7, 10'(ln * 16 + c));
        if (ln == 7 && c == 2)
          for (int j = 0; j < 7; j++) chk("t1_col", int'(dut_d[j]), (j + 1) * 16 + 2);
        if (ln == 2 && c == 0) begin
          chk("t2_d6", int'(d6), 'h20);
          chk("t2_d5", int'(d5), 'h10);
          for (int j = 0; j < 5; j++) chk("t2_low", int'(dut_d[j]), 0);
        end
        if (ln == 4 && c == 5) begin chk("t3_x5", int'(X), 0); chk("t3_y", int'(Y), 1); end
        if (ln == 4 && c == 6) chk("t3_x6", int'(X), 1);
        if (ln == 3 && c == 0) chk("t1_ov_first", int'(OUT_VALID), 1);
      end
      step(0, 0, 0, 0, '0);
      chk("t1_ov_idle", int'(OUT_VALID), 0);
      step(0, 0, 0, 0, '0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      step(0, tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].p);
      chk("tbl_ov", int'(OUT_VALID), int'(tbl[i].ov));
      chk("tbl_err", int'(ERR_LEN), int'(tbl[i].err));
      if (tbl[i].v && tbl[i].p == 10'h140) chk("drop_nowrite_d5", int'(d5), 'h130);
    end

    // Single-pixel line then a normal line.
    step(0, 1, 1, 1, 10'h2aa);
    chk("t6_err", int'(ERR_LEN), 1);
    idle(1);
    for (int c = 0; c < 8; c++) begin
      step(0, 1, 0, c == 7, 10'(16'h2b0 + c));
      if (c == 0) begin
        chk("t6_d5", int'(d5), 'h2aa);
        chk("t6_d6", int'(d6), 'h2b0);
`ifdef BORDER_REPLICATE_EN
        for (int j = 0; j < 5; j++) chk("t6_low", int'(dut_d[j]), 'h2aa);
`else
        for (int j = 0; j < 5; j++) chk("t6_low", int'(dut_d[j]), 0);
`endif
      end
    end
    idle(2);

    // Reset in the middle of line 5.
    for (int ln = 0; ln < 6; ln++) begin
      for (int c = 0; c < 8; c++) begin
        if (ln == 5 && c == 3) break;
        step(0, 1, ln == 0 && c == 0, c == 7, 10'(16'h300 + ln * 16 + c));
      end
      if (ln < 5) idle(1);
    end
    step(1, 1, 0, 0, 10'h353);
    for (int j = 0; j < 7; j++) chk("t5_rst_d", int'(dut_d[j]), 0);
    chk("t5_rst_ov", int'(OUT_VALID), 0);
    chk("t5_rst_x", int'(X), 0);
    chk("t5_rst_y", int'(Y), 0);
    idle(2);
    for (int c = 0; c < 8; c++) begin
      step(0, 1, c == 0, c == 7, 10'(16'h3f0 + c));
`ifdef BORDER_REPLICATE_EN
      for (int j = 0; j < 6; j++) chk("t5_first", int'(dut_d[j]), 16'h3f0 + c);
`else
      for (int j = 0; j < 6; j++) chk("t5_first", int'(dut_d[j]), 0);
`endif
    end
    idle(1);

    // Random frames, occasionally with short lines.
    for (int f = 0; f < 12; f++) begin
      int nl;
      nl = $urandom_range(1, 9);
      for (int ln = 0; ln < nl; ln++) begin
        int len;
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 8;
        for (int c = 0; c < len; c++)
          step(0, 1, f >= 0 && ln == 0 && c == 0, c == len - 1, 10'($urandom));
        idle($urandom_range(0, 3));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
